// File: rtl/led_pkg.sv
// Shared constants for the multi-channel LED pattern generator.
package led_pkg;

   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_ON      = 2'b01;
   localparam logic [1:0] MODE_BLINK   = 2'b10;
   localparam logic [1:0] MODE_BREATHE = 2'b11;

   localparam int PERIOD_W   = 16;
   localparam int MIN_PERIOD = 2;

   // Clock cycles per millisecond.
   function automatic int MS_DIV(input int clk_freq_hz);
      return clk_freq_hz / 1000;
   endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, millisecond phase counter, breathe
// ramp and the registered, optionally inverted, LED drive.
module led_channel
   import led_pkg::*;
#(
   parameter int         PWM_BITS      = 8,
   parameter logic [1:0] RST_MODE      = MODE_BLINK,
   parameter int         RST_PERIOD_MS = 1000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_tick,
   input  logic                i_wr,
   input  logic [1:0]          i_mode,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic                i_invert,
   input  logic [PWM_BITS-1:0] i_pwm_cnt,
   output logic                o_led
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   logic [1:0]          r_mode;
   logic [PERIOD_W-1:0] r_period;
   logic                r_invert;
   logic [PERIOD_W-1:0] r_ms_cnt;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_dir_down;
   logic                r_led;

   logic [PERIOD_W-1:0] w_period_clamped;
   logic                w_raw;

   assign w_period_clamped = (i_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : i_period;

   always_comb begin
      w_raw = 1'b0;
      case (r_mode)
         MODE_OFF:     w_raw = 1'b0;
         MODE_ON:      w_raw = 1'b1;
         MODE_BLINK:   w_raw = (r_ms_cnt < (r_period >> 1));
         MODE_BREATHE: w_raw = (i_pwm_cnt < r_duty);
         default:      w_raw = 1'b0;
      endcase
   end

   // A write restarts the channel's phase and takes priority over a tick.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode     <= RST_MODE;
         r_period   <= PERIOD_W'(RST_PERIOD_MS);
         r_invert   <= 1'b0;
         r_ms_cnt   <= '0;
         r_duty     <= '0;
         r_dir_down <= 1'b0;
         r_led      <= 1'b0;
      end else begin
         if (i_wr) begin
            r_mode     <= i_mode;
            r_period   <= w_period_clamped;
            r_invert   <= i_invert;
            r_ms_cnt   <= '0;
            r_duty     <= '0;
            r_dir_down <= 1'b0;
         end else if (i_tick) begin
            if (r_ms_cnt == r_period - PERIOD_W'(1))
               r_ms_cnt <= '0;
            else
               r_ms_cnt <= r_ms_cnt + PERIOD_W'(1);

            // Triangle ramp: direction flips on the step that reaches an end.
            if (!r_dir_down) begin
               r_duty <= r_duty + PWM_BITS'(1);
               if (r_duty + PWM_BITS'(1) == DUTY_MAX)
                  r_dir_down <= 1'b1;
            end else begin
               r_duty <= r_duty - PWM_BITS'(1);
               if (r_duty == PWM_BITS'(1))
                  r_dir_down <= 1'b0;
            end
         end
         r_led <= w_raw ^ r_invert;
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared ms prescaler and PWM counter,
// config write decode, and NUM_LED independent pattern channels.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int         CLK_FREQ_HZ   = 50_000_000,
   parameter int         NUM_LED       = 3,
   parameter int         PWM_BITS      = 8,
   parameter logic [1:0] RST_MODE      = 2'b10,
   parameter int         RST_PERIOD_MS = 1000
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cfg_we,
   input  logic [3:0]          cfg_sel,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period_ms,
   input  logic                cfg_invert,
   output logic [NUM_LED-1:0]  led,
   output logic                tick_ms
);

   localparam int DIV     = MS_DIV(CLK_FREQ_HZ);
   localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PWM_TOP = (2 ** PWM_BITS) - 2;

   logic [PRE_W-1:0]    r_presc;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                w_tick;
   logic [NUM_LED-1:0]  w_wr;
   logic [NUM_LED-1:0]  w_led;

   assign w_tick = (r_presc == PRE_W'(DIV - 1));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PRE_W'(1);
      end
   end

   // 2^PWM_BITS-1 states so that the all-ones duty is continuously on.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_pwm_cnt <= '0;
      end else if (r_pwm_cnt == PWM_BITS'(PWM_TOP)) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
   end

   // Only indices below NUM_LED have a channel, so out-of-range selects match nothing.
   for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
      assign w_wr[g] = cfg_we && (cfg_sel == 4'(g));

      led_channel #(
         .PWM_BITS      (PWM_BITS),
         .RST_MODE      (RST_MODE),
         .RST_PERIOD_MS (RST_PERIOD_MS)
      ) u_ch (
         .i_clk     (sys_clk),
         .i_rst     (sys_rst),
         .i_tick    (w_tick),
         .i_wr      (w_wr[g]),
         .i_mode    (cfg_mode),
         .i_period  (cfg_period_ms),
         .i_invert  (cfg_invert),
         .i_pwm_cnt (r_pwm_cnt),
         .o_led     (w_led[g])
      );
   end

   assign led     = w_led;
   assign tick_ms = w_tick;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel, parametrised successor to the board's single-pattern LED blinker. A shared millisecond prescaler drives NUM_LED independent channels. Each channel runs a runtime-selectable mode (off, on, blink, breathe) with a programmable period and output polarity. It sits between the top-level control/debug logic and the board LED pins.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; prescaler terminal count = CLK_FREQ_HZ/1000 - 1.
NUM_LED, 3, number of LED channels (1..16).
PWM_BITS, 8, breathe-mode PWM resolution.
RST_MODE, 2'b10, mode loaded into every channel at reset (blink).
RST_PERIOD_MS, 1000, blink period loaded at reset.

Ports:
sys_clk  input  1  system clock.
sys_rst  input  1  asynchronous reset, active-high.
cfg_we  input  1  one-cycle config write strobe.
cfg_sel  input  4  target channel index.
cfg_mode  input  2  00 off, 01 on, 10 blink, 11 breathe.
cfg_period_ms  input  16  blink period in ms.
cfg_invert  input  1  1 = drive channel active-low.
led  output  NUM_LED  registered LED drive.
tick_ms  output  1  one-cycle pulse each elapsed millisecond.

Behaviour:
- Reset (async, immediate): led = 0; tick_ms = 0; prescaler = 0.
- Reset, per channel: mode = RST_MODE, period = RST_PERIOD_MS, invert = 0, ms_cnt = 0, duty = 0, dir = up, pwm_cnt = 0.
- Prescaler: counts 0..CLK_FREQ_HZ/1000-1, then wraps to 0. tick_ms = 1 in the cycle the count equals the terminal value.
- ms_cnt (per channel): on tick_ms, if ms_cnt == period-1 it goes to 0, else it increments. It does not advance without a tick.
- Period clamp: a written period < 2 is stored as 2.
- Blink: raw = 1 while ms_cnt < period>>1, else 0. For odd periods the on-time is the floor.
- Breathe: duty (PWM_BITS wide) steps by 1 per tick_ms.
  - Counting up: on reaching 2^PWM_BITS-1, dir flips to down in the same step.
  - Counting down: on reaching 0, dir flips to up.
  - The period is ignored in this mode; a full cycle is 2*(2^PWM_BITS-1) ms (510 ms at 8 bits).
- PWM: pwm_cnt is free-running at sys_clk over 0..2^PWM_BITS-2 (255 states). raw = (pwm_cnt < duty). So duty 0 is fully off and duty 255 is fully on.
- Off: raw = 0. On: raw = 1.
- Output: led[i] <= raw ^ invert, registered, so there is 1 cycle of latency from internal state.
- Config write:
  - When cfg_we = 1 and cfg_sel < NUM_LED, the selected channel loads mode, period (clamped) and invert on that clock edge.
  - The same edge clears ms_cnt and duty and sets dir = up.
  - led reflects the new config on the following edge.
- cfg_sel >= NUM_LED: the write is ignored with no side effects.
- Write coinciding with tick_ms on the same channel: the write wins (counters = 0, no increment).
- Other channels are unaffected by a write.
- Writing a period smaller than the current ms_cnt is safe, because counters clear on every write.
- The prescaler is never disturbed by config writes.
- Reset asserted mid-pattern: all state returns to reset values immediately. Patterns restart in phase from 0 after deassertion.

Decomposition:
- Package led_pkg:
  - mode constants MODE_OFF/ON/BLINK/BREATHE (2-bit);
  - MS_DIV function computing CLK_FREQ_HZ/1000;
  - PERIOD_W = 16 and MIN_PERIOD = 2.
- Sub-module led_channel: one channel's config registers, ms_cnt, duty/dir and raw/invert output. It is instantiated NUM_LED times in a generate loop.
- The top level holds the prescaler, the shared pwm_cnt and write decode.

Test Plan:
1. CLK_FREQ_HZ=4000 (4 clk/ms), reset defaults, RST_PERIOD_MS=4 -> tick_ms every 4 cycles; each led = 1 for 2 ms (8 clk) then 0 for 8 clk, repeating; led = 0 during reset.
2. Write ch1 mode=11, PWM_BITS=2 -> duty sequence 0,1,2,3,2,1,0 per ms. With duty 1 the led is high 1 of every 3 clocks; duty 3 gives constant 1; duty 0 gives constant 0.
3. Write ch0 period=5 then period=0 -> period 5: on 2 ms, off 3 ms. Period 0 is stored as 2: on 1 ms, off 1 ms.
4. Write ch2 invert=1, mode=01 -> led[2] = 0 on the cycle after the write edge; ch0 and ch1 keep their phase. Then write cfg_sel=7 -> no change on any channel.
5. Assert cfg_we on the exact cycle tick_ms=1 for ch0 -> ch0 ms_cnt = 0 afterwards (no increment); ch1 increments normally.
6. Assert sys_rst mid-blink with an asynchronous edge -> led = 0 before the next sys_clk edge. After release, the first tick_ms comes 4 cycles later and all channels restart in phase.
